// File: rtl/subservient_uart_pkg.sv
// Shared definitions for the subservient UART blocks (TX and RX).
// Holds FSM encodings, Wishbone register offsets and STATUS bit layout.
package subservient_uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_t;

   localparam logic UART_DATA   = 1'b0;
   localparam logic UART_STATUS = 1'b1;

   localparam int STATUS_BUSY_BIT  = 0;
   localparam int STATUS_FULL_BIT  = 1;
   localparam int STATUS_COUNT_LSB = 2;

endpackage

// File: rtl/subservient_fifo_sync.sv
// Register-based synchronous FIFO with show-ahead read data.
// Pointers are AW bits wide so they wrap modulo the depth on their own.
module subservient_fifo_sync
   import subservient_uart_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int AW    = 2
)
(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty,
   output logic [AW:0]      o_count
);

   localparam int          DEPTH    = 2**AW;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign o_full   = (count == FULL_CNT);
   assign o_empty  = (count == '0);
   assign do_push  = i_push & ~o_full;
   assign do_pop   = i_pop & ~o_empty;
   assign o_rdata  = mem[rd_ptr];
   assign o_count  = count;

   always_ff @(posedge i_clk) begin
      if (do_push) begin
         mem[wr_ptr] <= i_wdata;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         // simultaneous push and pop leaves the occupancy unchanged
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/subservient_uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO behind a Wishbone slave port.
// DATA writes stall (ack withheld) while the FIFO is full; STATUS reports busy/full/count.
module subservient_uart_tx
   import subservient_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_AW      = 2
)
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_wb_adr,
   input  logic [7:0]  i_wb_dat,
   input  logic        i_wb_we,
   input  logic        i_wb_stb,
   output logic [31:0] o_wb_rdt,
   output logic        o_wb_ack,
   output logic        o_tx
);

   localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

   tx_state_t          state;
   logic [BAUD_W-1:0]  baud_cnt;
   logic [2:0]         bit_idx;
   logic [7:0]         shift;
   logic               baud_done;

   logic [7:0]         fifo_rdata;
   logic               fifo_full;
   logic               fifo_empty;
   logic [FIFO_AW:0]   fifo_count;
   logic               fifo_push;
   logic               fifo_pop;

   logic               wb_req;
   logic               wb_accept;
   logic               data_wr;
   logic               status_rd;
   logic               busy;
   logic [31:0]        status_word;

   subservient_fifo_sync #(
      .WIDTH (8),
      .AW    (FIFO_AW)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (fifo_push),
      .i_wdata (i_wb_dat),
      .i_pop   (fifo_pop),
      .o_rdata (fifo_rdata),
      .o_full  (fifo_full),
      .o_empty (fifo_empty),
      .o_count (fifo_count)
   );

   // Full is taken from the registered count, so a pop this cycle never frees room this cycle.
   assign wb_req    = i_wb_stb & ~o_wb_ack;
   assign data_wr   = (i_wb_adr == UART_DATA) & i_wb_we;
   assign status_rd = (i_wb_adr == UART_STATUS) & ~i_wb_we;
   assign wb_accept = ~(data_wr & fifo_full);
   assign fifo_push = wb_req & data_wr & ~fifo_full;

   assign baud_done = (baud_cnt == BAUD_LAST);
   assign fifo_pop  = ~fifo_empty &
                      ((state == ST_IDLE) | ((state == ST_STOP) & baud_done));
   assign busy      = (state != ST_IDLE) | ~fifo_empty;

   always_comb begin
      status_word                                      = '0;
      status_word[STATUS_BUSY_BIT]                     = busy;
      status_word[STATUS_FULL_BIT]                     = fifo_full;
      status_word[STATUS_COUNT_LSB +: FIFO_AW+1]       = fifo_count;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_wb_ack <= 1'b0;
         o_wb_rdt <= '0;
      end else begin
         o_wb_ack <= wb_req & wb_accept;
         o_wb_rdt <= (wb_req & status_rd) ? status_word : '0;
      end
   end

   // Shift register carries payload only; it is reloaded on every pop.
   always_ff @(posedge i_clk) begin
      if (fifo_pop) begin
         shift <= fifo_rdata;
      end else if ((state == ST_DATA) && baud_done && (bit_idx != 3'd7)) begin
         shift <= shift >> 1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state    <= ST_IDLE;
         o_tx     <= 1'b1;
         baud_cnt <= '0;
         bit_idx  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               o_tx     <= 1'b1;
               baud_cnt <= '0;
               if (fifo_pop) begin
                  state <= ST_START;
                  o_tx  <= 1'b0;
               end
            end
            ST_START: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  state    <= ST_DATA;
                  o_tx     <= shift[0];
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            ST_DATA: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     state <= ST_STOP;
                     o_tx  <= 1'b1;
                  end else begin
                     // shift[1] is the bit that lands in shift[0] on this same edge
                     o_tx    <= shift[1];
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            ST_STOP: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  if (fifo_pop) begin
                     state <= ST_START;
                     o_tx  <= 1'b0;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               o_tx  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_subservient_uart_tx.sv
// Directed bench for subservient_uart_tx: frame-level line model plus a UART decoder.
module tb_subservient_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int MAXC  = 4096;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        adr = 1'b0;
   logic        we  = 1'b0;
   logic        stb = 1'b0;
   logic [7:0]  dat = 8'h00;
   logic [31:0] rdt;
   logic        ack;
   logic        tx;

   subservient_uart_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_AW      (2)
   ) dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_wb_adr (adr),
      .i_wb_dat (dat),
      .i_wb_we  (we),
      .i_wb_stb (stb),
      .o_wb_rdt (rdt),
      .o_wb_ack (ack),
      .o_tx     (tx)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   bit   chk_en = 1'b0;

   // frame k: pushed at edge fr_push, line occupied over edges [fr_start, fr_end)
   int         fr_push[$];
   int         fr_start[$];
   int         fr_end[$];
   logic [7:0] fr_byte[$];
   bit         exp_ack [MAXC];
   logic [31:0] exp_rdt [MAXC];
   int         last_ack = -10;

   bit         dec_active = 1'b0;
   int         dec_start  = 0;
   logic [7:0] dec_byte   = 8'h00;
   logic [7:0] rx_q[$];
   int         starts[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   function automatic int count_before(input int e);
      int n = 0;
      foreach (fr_push[i]) begin
         if (fr_push[i] <= e - 1) n++;
         if (fr_start[i] <= e - 1) n--;
      end
      return n;
   endfunction

   function automatic bit line_active(input int e);
      foreach (fr_start[i]) begin
         if (fr_start[i] <= e - 1 && e - 1 < fr_end[i]) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic int last_end();
      int m = 0;
      foreach (fr_end[i]) if (fr_end[i] > m) m = fr_end[i];
      return m;
   endfunction

   function automatic logic model_tx(input int t);
      int k;
      foreach (fr_start[i]) begin
         if (fr_start[i] <= t && t < fr_end[i]) begin
            k = (t - fr_start[i]) / CPB;
            if (k == 0) return 1'b0;
            if (k == 9) return 1'b1;
            return fr_byte[i][k-1];
         end
      end
      return 1'b1;
   endfunction

   function automatic logic [31:0] model_status(input int e);
      int          n;
      logic [31:0] s;
      n    = count_before(e);
      s    = '0;
      s[0] = line_active(e) || (n > 0);
      s[1] = (n == DEPTH);
      s[4:2] = 3'(n);
      return s;
   endfunction

   // One clock: advance to the falling edge, then check the line and bus against the model.
   task automatic tick();
      int off;
      int b;
      @(negedge clk);
      cyc++;
      if (cyc >= MAXC) begin
         $display("FAIL cycle budget exceeded at edge %0d", cyc);
         $fatal(1, "cycle budget");
      end
      if (rst) dec_active = 1'b0;
      if (chk_en) begin
         check("tx", 32'(tx), 32'(model_tx(cyc)));
         check("ack", 32'(ack), 32'(exp_ack[cyc]));
         if (exp_ack[cyc]) check("rdt", rdt, exp_rdt[cyc]);
         if (dec_active) begin
            off = cyc - dec_start;
            if (off % CPB == CPB / 2) begin
               b = off / CPB;
               if (b >= 1 && b <= 8) dec_byte[b-1] = tx;
               if (b == 9) begin
                  check("stop bit", 32'(tx), 32'd1);
                  rx_q.push_back(dec_byte);
                  dec_active = 1'b0;
               end
            end
         end else if (tx === 1'b0 && !rst) begin
            dec_active = 1'b1;
            dec_start  = cyc;
            starts.push_back(cyc);
         end
      end
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick();
   endtask

   task automatic access(input bit w, input bit a, input logic [7:0] d, output int ack_e);
      int e;
      int st;
      e = (cyc + 1 > last_ack + 2) ? cyc + 1 : last_ack + 2;
      if (w && a == 1'b0) begin
         while (count_before(e) >= DEPTH) e++;
         st = (e + 1 > last_end()) ? e + 1 : last_end();
         fr_push.push_back(e);
         fr_start.push_back(st);
         fr_end.push_back(st + 10 * CPB);
         fr_byte.push_back(d);
      end
      exp_ack[e] = 1'b1;
      exp_rdt[e] = (!w && a) ? model_status(e) : 32'h0;
      last_ack   = e;
      adr = a; we = w; dat = d; stb = 1'b1;
      wait_until(e);
      stb = 1'b0; we = 1'b0;
      ack_e = e;
   endtask

   task automatic reset_pulse();
      int r;
      r = cyc + 1;
      for (int i = fr_start.size() - 1; i >= 0; i--) begin
         if (fr_start[i] >= r) begin
            fr_start.delete(i); fr_end.delete(i); fr_push.delete(i); fr_byte.delete(i);
         end else if (fr_end[i] > r) begin
            fr_end[i] = r;
         end
      end
      rst = 1'b1;
      tick();
      check("tx after reset edge", 32'(tx), 32'd1);
      rst = 1'b0;
   endtask

   initial begin
      int          a [6];
      int          s0;
      int          n0;
      int          dummy;
      logic [9:0]  pat55;
      logic [3:0]  pat_ack;
      logic [7:0]  six [6];
      pat55   = 10'b1010101010;
      pat_ack = 4'b0101;
      six     = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};

      repeat (2) tick();
      check("reset tx", 32'(tx), 32'd1);
      check("reset ack", 32'(ack), 32'd0);
      check("reset rdt", rdt, 32'd0);
      tick();
      rst    = 1'b0;
      chk_en = 1'b1;

      tick();
      access(1'b0, 1'b1, 8'h00, a[0]);
      check("status after reset", rdt, 32'h0);

      // single byte 0x55
      tick();
      rx_q.delete(); starts.delete();
      s0 = cyc;
      access(1'b1, 1'b0, 8'h55, a[0]);
      check("ack latency", 32'(a[0] - s0), 32'd1);
      check("ack seen", 32'(ack), 32'd1);
      wait_until(s0 + 2);
      check("tx fall edge", 32'(tx), 32'd0);
      for (int k = 0; k < 10; k++) begin
         wait_until(s0 + 2 + k * CPB + 1);
         check("frame 0x55 bit", 32'(tx), 32'(pat55[k]));
      end
      wait_until(s0 + 2 + 10 * CPB + 4);
      check("U count", 32'(rx_q.size()), 32'd1);
      if (rx_q.size() == 1) check("U byte", 32'(rx_q[0]), 32'h55);
      if (starts.size() >= 1) check("U start edge", 32'(starts[0] - s0), 32'd2);

      // back-to-back "Hi"
      tick();
      rx_q.delete(); starts.delete();
      s0 = cyc;
      access(1'b1, 1'b0, 8'h48, a[0]);
      access(1'b1, 1'b0, 8'h69, a[1]);
      wait_until(s0 + 2 + 20 * CPB + 8);
      check("Hi count", 32'(rx_q.size()), 32'd2);
      if (rx_q.size() == 2) begin
         check("Hi byte0", 32'(rx_q[0]), 32'h48);
         check("Hi byte1", 32'(rx_q[1]), 32'h69);
      end
      if (starts.size() == 2) check("Hi no gap", 32'(starts[1] - starts[0]), 32'd40);

      // six writes without polling, plus an abandoned strobe while full
      tick();
      rx_q.delete(); starts.delete();
      for (int i = 0; i < 5; i++) access(1'b1, 1'b0, six[i], a[i]);
      check("writes 1-5 prompt", 32'(a[4] - a[0]), 32'd8);
      access(1'b0, 1'b1, 8'h00, dummy);
      check("status full", rdt, 32'h13);
      adr = 1'b0; we = 1'b1; dat = 8'hEE; stb = 1'b1;
      repeat (2) tick();
      stb = 1'b0; we = 1'b0;
      access(1'b1, 1'b0, six[5], a[5]);
      check("stalled write ack", 32'(a[5] - a[0]), 32'd42);
      wait_until(a[0] + 1 + 6 * 10 * CPB + 8);
      access(1'b0, 1'b1, 8'h00, dummy);
      check("status drained", rdt, 32'h0);
      check("six count", 32'(rx_q.size()), 32'd6);
      if (rx_q.size() == 6) begin
         for (int i = 0; i < 6; i++) check("six byte", 32'(rx_q[i]), 32'(six[i]));
      end

      // reset during data bit 3 with two bytes queued
      tick();
      rx_q.delete(); starts.delete();
      s0 = cyc;
      access(1'b1, 1'b0, 8'h11, a[0]);
      access(1'b1, 1'b0, 8'h22, a[1]);
      access(1'b1, 1'b0, 8'h33, a[2]);
      wait_until(s0 + 2 + 4 * CPB);
      reset_pulse();
      tick();
      access(1'b0, 1'b1, 8'h00, dummy);
      check("status after mid-frame reset", rdt, 32'h0);
      n0 = starts.size();
      wait_until(cyc + 120);
      check("no frames after reset", 32'(starts.size() - n0), 32'd0);
      check("no bytes after reset", 32'(rx_q.size()), 32'd0);

      // held strobe on STATUS: ack alternates
      tick();
      s0 = cyc;
      exp_ack[s0 + 1] = 1'b1; exp_rdt[s0 + 1] = model_status(s0 + 1);
      exp_ack[s0 + 3] = 1'b1; exp_rdt[s0 + 3] = model_status(s0 + 3);
      last_ack = s0 + 3;
      adr = 1'b1; we = 1'b0; stb = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("held ack", 32'(ack), 32'(pat_ack[k]));
      end
      stb = 1'b0;
      repeat (4) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/subservient_uart_tx.md
# subservient_uart_tx

Hardware 8N1 UART transmitter with a 4-entry byte FIFO and a Wishbone slave port, for the subservient SoC peripheral bus. It replaces bit-banged GPIO UART output: firmware writes bytes, and the block serialises them on `o_tx`. The bench's UART decoder, run at the matching baud rate, is the receiving end.

## Interface
Parameters:
- `CLKS_PER_BIT`, 868: clock cycles per serial bit (100 MHz / 115200). Legal range is ≥ 2.
- `FIFO_AW`, 2: log2 of the FIFO depth. The depth is `2**FIFO_AW`.

Ports:
- `i_clk` in 1: single clock.
- `i_rst` in 1: synchronous, active-high reset.
- `i_wb_adr` in 1: 0 selects DATA, 1 selects STATUS.
- `i_wb_dat` in 8: write byte.
- `i_wb_we` in 1: write enable.
- `i_wb_stb` in 1: strobe, held until ack.
- `o_wb_rdt` out 32: read data.
- `o_wb_ack` out 1: one-cycle acknowledge.
- `o_tx` out 1: serial output. Idle level is high.

## Operation
- Reset values: `o_tx`=1, `o_wb_ack`=0, `o_wb_rdt`=0, FSM=IDLE, FIFO empty with count 0.
- DATA write (`adr`=0, `we`=1): the byte is pushed when the FIFO is not full.
  - If the FIFO is full, ack is withheld and the master stalls until an entry frees.
  - The full check uses the registered count. A pop in the same cycle does not allow a same-cycle push.
- STATUS read (`adr`=1):
  - `rdt[0]` = busy (FSM ≠ IDLE or FIFO non-empty).
  - `rdt[1]` = full.
  - `rdt[2+:FIFO_AW+1]` = FIFO count.
  - All other bits are 0.
- DATA read returns 0. STATUS write is acked and ignored.
- Ack rule: `o_wb_ack <= i_wb_stb & !o_wb_ack & accept`.
  - `accept` = 1 for every access except a DATA write while the FIFO is full.
  - Ack never holds high two consecutive cycles.
  - `o_wb_rdt` is valid while ack is high.
- TX FSM states: IDLE, START, DATA, STOP. A baud counter counts 0..`CLKS_PER_BIT`-1, and a bit index counts 0..7.
  - IDLE: `o_tx`=1. If the FIFO is non-empty, pop into the shift register, go to START and drive `o_tx`=0 on the same edge.
  - START: after `CLKS_PER_BIT` cycles go to DATA. `o_tx` = shift[0].
  - DATA: every `CLKS_PER_BIT` cycles shift right (LSB first) and increment the index. After bit 7 has been held its full period, go to STOP with `o_tx`=1.
  - STOP: after `CLKS_PER_BIT` cycles:
    - if the FIFO is non-empty, pop, go to START and drive `o_tx`=0 (no idle gap between frames);
    - otherwise go to IDLE.
- A simultaneous push and pop keeps the count unchanged. Write and read pointers wrap modulo the depth.

## Timing
- A frame is exactly 10×`CLKS_PER_BIT` cycles of `o_tx`: start bit, 8 data bits, stop bit.
- Write latency with the FSM idle and the FIFO empty:
  - The strobe is sampled at edge N.
  - Ack is high and the push occurs at edge N+1.
  - The pop occurs and `o_tx` falls at edge N+2.
- Back-to-back frames: the stop bit of frame k is immediately followed by the start bit of frame k+1.
- Full FIFO: a stalled DATA write is acked on the edge after the FSM pops an entry.
- Reset mid-frame: on the first reset edge, `o_tx` returns to 1, the FIFO is flushed, any pending ack is dropped and the FSM goes to IDLE. No partial byte is resumed.
- Strobe deasserted before ack: the access is abandoned and nothing is pushed.

## Structure
- Shared package `subservient_uart_pkg` holds:
  - FSM state encodings (IDLE=0, START=1, DATA=2, STOP=3);
  - register offsets `UART_DATA`=0 and `UART_STATUS`=1;
  - STATUS bit positions.
  The matching RX block uses the same package.
- One sub-module, `subservient_fifo_sync`:
  - parameterised width/depth, register-based;
  - push/pop/full/empty/count interface;
  - contains the pointer wrap logic.
- The top level holds the Wishbone decode, ack logic, baud counter and TX FSM.

## Test plan
All scenarios use `CLKS_PER_BIT`=4, and the bench UART decoder runs at the matching baud rate.
- Write 0x55 after reset → ack one cycle after stb. `o_tx` falls 2 edges after stb, then shows 0,1,0,1,0,1,0,1,0,1 (start, LSB-first 0x55, stop) at 4 cycles per bit. The decoder prints "U".
- Write 0x48, 0x69 back-to-back → 80 contiguous cycles of framing with no idle high gap between the stop and start bits. The decoder prints "Hi".
- Write 6 bytes without polling → writes 1–5 ack promptly (one is popped immediately and four fill the FIFO). Write 6 stalls until the first frame ends, then acks on the edge after the pop.
- STATUS reads → 0 after reset. With 4 queued bytes: full=1, count=4, busy=1. After all frames drain: 0 again.
- Assert `i_rst` for one cycle during bit 3 of a frame with 2 bytes queued → `o_tx`=1 on the next edge, STATUS reads 0, and no further frames are emitted.
- Hold `i_wb_stb` high across repeated STATUS reads → ack alternates 1,0,1,0. It is never high two consecutive cycles.
